// File: rtl/hbridge_dead_time_driver.sv
// H-bridge leg driver: filters the duty sign, inserts dead time on every
// direction change or enable, and routes the PWM pulse to one leg at a time.
module hbridge_dead_time_driver #(
  parameter int DEAD_TICKS   = 16,
  parameter int FILTER_TICKS = 4,
  parameter int CNT_W        = 8
) (
  input  logic clk_in,
  input  logic async_reset_in,
  input  logic CE_in,
  input  logic enable_in,
  input  logic pwm_in,
  input  logic sign_in,
  output logic leg_a_out,
  output logic leg_b_out,
  output logic dir_out,
  output logic dead_out
);

  typedef enum logic [1:0] {IDLE, DEAD, FWD, REV} state_t;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TICKS - 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] dead_cnt, dead_cnt_nx;
  logic [CNT_W-1:0] filt_cnt, filt_cnt_nx;
  logic             sign_filt, sign_filt_nx;
  logic             target, target_nx;
  logic             leg_a_nx, leg_b_nx, dir_nx, dead_nx;

  // The FSM deliberately reacts to the registered sign_filt, so a newly
  // accepted sign takes effect one tick after the filter toggles.
  always_comb begin
    filt_cnt_nx  = filt_cnt;
    sign_filt_nx = sign_filt;
    if (CE_in) begin
      if (sign_in == sign_filt) begin
        filt_cnt_nx = '0;
      end else if (filt_cnt == FILT_LAST) begin
        sign_filt_nx = ~sign_filt;
        filt_cnt_nx  = '0;
      end else begin
        filt_cnt_nx = filt_cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    dead_cnt_nx = dead_cnt;
    target_nx   = target;
    if (CE_in) begin
      if (!enable_in) begin
        state_nx = IDLE;
      end else begin
        case (state)
          IDLE: begin
            state_nx    = DEAD;
            target_nx   = sign_filt;
            dead_cnt_nx = '0;
          end
          DEAD: begin
            if (sign_filt != target) begin
              target_nx   = sign_filt;
              dead_cnt_nx = '0;
            end else if (dead_cnt == DEAD_LAST) begin
              state_nx = target ? REV : FWD;
            end else begin
              dead_cnt_nx = dead_cnt + CNT_ONE;
            end
          end
          FWD: begin
            if (sign_filt) begin
              state_nx    = DEAD;
              target_nx   = 1'b1;
              dead_cnt_nx = '0;
            end
          end
          REV: begin
            if (!sign_filt) begin
              state_nx    = DEAD;
              target_nx   = 1'b0;
              dead_cnt_nx = '0;
            end
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  // Outputs are decoded from the next state so legs drop on the very tick
  // that leaves a drive state and the first drive lands on the exit tick.
  always_comb begin
    leg_a_nx = leg_a_out;
    leg_b_nx = leg_b_out;
    dir_nx   = dir_out;
    dead_nx  = dead_out;
    if (CE_in) begin
      leg_a_nx = (state_nx == FWD) && pwm_in;
      leg_b_nx = (state_nx == REV) && pwm_in;
      dead_nx  = (state_nx == DEAD);
      if (state_nx == FWD) dir_nx = 1'b0;
      if (state_nx == REV) dir_nx = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge async_reset_in) begin
    if (async_reset_in) begin
      state     <= IDLE;
      dead_cnt  <= '0;
      filt_cnt  <= '0;
      sign_filt <= 1'b0;
      target    <= 1'b0;
      leg_a_out <= 1'b0;
      leg_b_out <= 1'b0;
      dir_out   <= 1'b0;
      dead_out  <= 1'b0;
    end else begin
      state     <= state_nx;
      dead_cnt  <= dead_cnt_nx;
      filt_cnt  <= filt_cnt_nx;
      sign_filt <= sign_filt_nx;
      target    <= target_nx;
      leg_a_out <= leg_a_nx;
      leg_b_out <= leg_b_nx;
      dir_out   <= dir_nx;
      dead_out  <= dead_nx;
    end
  end

endmodule

// File: tb/tb_hbridge_dead_time_driver.sv
// Scoreboard bench for hbridge_dead_time_driver: a tick-level behavioural
// model predicts outputs, a monitor compares them one clock later.
module tb_hbridge_dead_time_driver;

  localparam int DT = 16;
  localparam int FT = 4;
  localparam int M_IDLE = 0, M_DEAD = 1, M_FWD = 2, M_REV = 3;

  logic clk = 1'b0;
  logic rst, ce, en, pwm, sgn;
  logic la, lb, dir, dead;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  int   m_mode;
  int   m_elapsed;
  bit   m_filt, m_tgt, m_dir;
  bit   hist[$];
  logic [3:0] m_out;

  always #5 clk = ~clk;

  hbridge_dead_time_driver #(
    .DEAD_TICKS  (DT),
    .FILTER_TICKS(FT),
    .CNT_W       (8)
  ) dut (
    .clk_in        (clk),
    .async_reset_in(rst),
    .CE_in         (ce),
    .enable_in     (en),
    .pwm_in        (pwm),
    .sign_in       (sgn),
    .leg_a_out     (la),
    .leg_b_out     (lb),
    .dir_out       (dir),
    .dead_out      (dead)
  );

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_elapsed = 0;
    m_filt    = 1'b0;
    m_tgt     = 1'b0;
    m_dir     = 1'b0;
    hist.delete();
    m_out     = 4'b0000;
  endtask

  // One CE tick: the bridge acts on the sign accepted before this tick; the
  // accepted sign flips once the last FT samples all disagree with it.
  task automatic model_step(input bit e, input bit p, input bit s);
    bit f;
    bit all_diff;
    f = m_filt;
    if (!e) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: begin m_mode = M_DEAD; m_tgt = f; m_elapsed = 1; end
        M_DEAD: begin
          if (f != m_tgt) begin m_tgt = f; m_elapsed = 1; end
          else if (m_elapsed == DT) m_mode = m_tgt ? M_REV : M_FWD;
          else m_elapsed++;
        end
        M_FWD: if (f) begin m_mode = M_DEAD; m_tgt = 1'b1; m_elapsed = 1; end
        default: if (!f) begin m_mode = M_DEAD; m_tgt = 1'b0; m_elapsed = 1; end
      endcase
    end
    if (m_mode == M_FWD) m_dir = 1'b0;
    if (m_mode == M_REV) m_dir = 1'b1;
    m_out = {(m_mode == M_FWD) && p, (m_mode == M_REV) && p, m_dir, m_mode == M_DEAD};
    hist.push_back(s);
    if (hist.size() > FT) void'(hist.pop_front());
    if (hist.size() == FT) begin
      all_diff = 1'b1;
      foreach (hist[i]) if (hist[i] == f) all_diff = 1'b0;
      if (all_diff) m_filt = ~f;
    end
  endtask

  task automatic cycle(input bit c, input bit e, input bit p, input bit s);
    @(negedge clk);
    ce  = c;
    en  = e;
    pwm = p;
    sgn = s;
    if (c) model_step(e, p, s);
    exp_q.push_back(m_out);
  endtask

  task automatic async_reset_mid_cycle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({la, lb, dir, dead} !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset got a/b/dir/dead=%b required=0000", {la, lb, dir, dead});
    end
    repeat (2) @(negedge clk);
    ce  = 1'b0;
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({la, lb, dir, dead} !== e) begin
        failures++;
        $display("FAIL outputs t=%0t got a/b/dir/dead=%b required=%b", $time, {la, lb, dir, dead}, e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (la && lb) begin
        failures++;
        $display("FAIL shoot_through t=%0t got a=%b b=%b required not both 1", $time, la, lb);
      end
    end
  end

  initial begin
    int run_left;
    bit cur_sgn;
    bit c, e;
    rst = 1'b1; ce = 1'b0; en = 1'b0; pwm = 1'b0; sgn = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({la, lb, dir, dead} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state got a/b/dir/dead=%b required=0000", {la, lb, dir, dead});
    end
    @(negedge clk);
    rst = 1'b0;

    // enable, forward drive with varying pulse widths
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, (i % 3) == 0, 1'b0);
    // held reversal into REV
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, (i % 2) == 0, 1'b1);
    // back to FWD
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    // chatter: 3-clock pulses at 1
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), (i % 6) < 3);
    // re-reversal 8 clocks into DEAD
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, (i % 4) != 0, 1'b0);
    // CE 1 in 4, reverse then drop enable mid-REV
    for (int i = 0; i < 200; i++) cycle((i % 4) == 0, 1'b1, (i % 8) < 4, 1'b1);
    for (int i = 0; i < 20; i++) cycle((i % 4) == 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    // drop and re-enable, then async reset mid-DEAD
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    async_reset_mid_cycle();
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, (i % 2) == 1, 1'b0);

    // randomized sign runs, CE density and enable drops
    run_left = 0;
    cur_sgn  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        cur_sgn  = ~cur_sgn;
        run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 6);
      end
      run_left--;
      c = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 199) != 0);
      cycle(c, e, 1'($urandom_range(0, 1)), cur_sgn);
      if (i == 1500) async_reset_mid_cycle();
    end

    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
